// File: rtl/ro_puf_controller.sv
// ro_puf_controller: challenge/response sequencer for a ring-oscillator PUF bank.
// Defining RO_PUF_COUNTS_OUT_EN exposes the final toggle counts on count_a/count_b.
module ro_puf_controller #(
    parameter int NUM_RO     = 16,
    parameter int SEL_W      = 4,
    parameter int WIN_W      = 16,
    parameter int CNT_W      = 16,
    parameter int CLR_CYC    = 4,
    parameter int SETTLE_CYC = 4
) (
    input  logic              d_clk,
    input  logic              reset,
    input  logic              start,
    output logic              ready,
    input  logic [SEL_W-1:0]  chal_a,
    input  logic [SEL_W-1:0]  chal_b,
    input  logic [WIN_W-1:0]  window,
    output logic [NUM_RO-1:0] ro_enable,
    output logic              ro_reset,
    input  logic [NUM_RO-1:0] ro_in,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_bit,
    output logic              resp_tie,
    output logic              resp_err
`ifdef RO_PUF_COUNTS_OUT_EN
    ,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b
`endif
);
    typedef enum logic [2:0] {IDLE, CLEAR, SETTLE, MEASURE, COMPARE, DONE} state_t;
    state_t state_q, state_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [WIN_W-1:0] win_q, win_d, ph_q, ph_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [2:0] sync_a_q, sync_b_q;
    logic sat_q, sat_d, bit_q, bit_d, tie_q, tie_d, err_q, err_d;
    logic bad_chal, edge_a, edge_b;

    assign ready      = (state_q == IDLE) & ~reset;
    assign ro_reset   = state_q == CLEAR;
    assign resp_valid = state_q == DONE;
    assign resp_bit   = bit_q;
    assign resp_tie   = tie_q;
    assign resp_err   = err_q;
    assign ro_enable  = (state_q inside {CLEAR, SETTLE, MEASURE})
                      ? (NUM_RO'(1) << sel_a_q) | (NUM_RO'(1) << sel_b_q) : '0;
`ifdef RO_PUF_COUNTS_OUT_EN
    assign count_a = cnt_a_q;
    assign count_b = cnt_b_q;
`endif
    assign bad_chal = (chal_a == chal_b) || (window == '0)
                    || ({1'b0, chal_a} >= (SEL_W+1)'(NUM_RO))
                    || ({1'b0, chal_b} >= (SEL_W+1)'(NUM_RO));
    // Count any change between the 2nd and 3rd synchronizer stages.
    assign edge_a = sync_a_q[2] ^ sync_a_q[1];
    assign edge_b = sync_b_q[2] ^ sync_b_q[1];

    always_comb begin
        state_d = state_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        win_d   = win_q;
        ph_d    = ph_q + 1'b1;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        sat_d   = sat_q;
        bit_d   = bit_q;
        tie_d   = tie_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (start && ready) begin
                sel_a_d = chal_a;
                sel_b_d = chal_b;
                win_d   = window;
                ph_d    = '0;
                bit_d   = 1'b0;
                tie_d   = 1'b0;
                err_d   = bad_chal;
                state_d = bad_chal ? DONE : CLEAR;
            end
            CLEAR: begin
                cnt_a_d = '0;
                cnt_b_d = '0;
                sat_d   = 1'b0;
                if (ph_q == WIN_W'(CLR_CYC - 1)) begin
                    ph_d    = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: if (ph_q == WIN_W'(SETTLE_CYC - 1)) begin
                ph_d    = '0;
                state_d = MEASURE;
            end
            MEASURE: begin
                cnt_a_d = cnt_a_q + CNT_W'(edge_a && cnt_a_q != '1);
                cnt_b_d = cnt_b_q + CNT_W'(edge_b && cnt_b_q != '1);
                sat_d   = sat_q | (&cnt_a_d) | (&cnt_b_d);
                state_d = (ph_q == win_q - 1'b1) ? COMPARE : MEASURE;
            end
            COMPARE: begin
                bit_d   = cnt_a_q > cnt_b_q;
                tie_d   = cnt_a_q == cnt_b_q;
                err_d   = sat_q;
                state_d = DONE;
            end
            DONE: state_d = resp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge d_clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sel_a_q  <= '0;
            sel_b_q  <= '0;
            win_q    <= '0;
            ph_q     <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            sync_a_q <= '0;
            sync_b_q <= '0;
            sat_q    <= 1'b0;
            bit_q    <= 1'b0;
            tie_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_a_q  <= sel_a_d;
            sel_b_q  <= sel_b_d;
            win_q    <= win_d;
            ph_q     <= ph_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            sync_a_q <= {sync_a_q[1:0], ro_in[sel_a_q]};
            sync_b_q <= {sync_b_q[1:0], ro_in[sel_b_q]};
            sat_q    <= sat_d;
            bit_q    <= bit_d;
            tie_q    <= tie_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_ro_puf_controller.sv
// tb_ro_puf_controller: directed checks of the PUF sequencer against toggle-flop oscillator models.
module tb_ro_puf_controller;
    logic        d_clk = 1'b0, reset = 1'b1;
    logic        start = 1'b0, start1 = 1'b0, resp_ready = 1'b0;
    logic [3:0]  chal_a = '0, chal_b = '0;
    logic [15:0] window = '0;
    logic [15:0] ro_in = '0;
    logic        ready, ro_reset, resp_valid, resp_bit, resp_tie, resp_err;
    logic [15:0] ro_enable;
    logic        ready1, ro_reset1, resp_valid1, resp_bit1, resp_tie1, resp_err1;
    logic [15:0] ro_enable1;
`ifdef RO_PUF_COUNTS_OUT_EN
    logic [15:0] count_a, count_b;
    logic [3:0]  count_a1, count_b1;
`endif
    int total = 0, bad = 0, cyc = 0;
    int ia = 0, ib = 1, pa = 0, pb = 0, ca = 0, cb = 0;
    logic ta = 1'b0, tb_t = 1'b0, seen;

    ro_puf_controller dut (
        .d_clk(d_clk), .reset(reset), .start(start), .ready(ready),
        .chal_a(chal_a), .chal_b(chal_b), .window(window),
        .ro_enable(ro_enable), .ro_reset(ro_reset), .ro_in(ro_in),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_bit(resp_bit), .resp_tie(resp_tie), .resp_err(resp_err)
`ifdef RO_PUF_COUNTS_OUT_EN
        , .count_a(count_a), .count_b(count_b)
`endif
    );

    ro_puf_controller #(.CNT_W(4)) dut4 (
        .d_clk(d_clk), .reset(reset), .start(start1), .ready(ready1),
        .chal_a(chal_a), .chal_b(chal_b), .window(window),
        .ro_enable(ro_enable1), .ro_reset(ro_reset1), .ro_in(ro_in),
        .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_bit(resp_bit1), .resp_tie(resp_tie1), .resp_err(resp_err1)
`ifdef RO_PUF_COUNTS_OUT_EN
        , .count_a(count_a1), .count_b(count_b1)
`endif
    );

    always #5 d_clk = ~d_clk;

    // Toggle-flop oscillator models: cleared by ro_reset, toggle every pa/pb enabled cycles.
    initial forever begin
        @(negedge d_clk);
        if (ro_reset | ro_reset1) begin
            ca = 0; cb = 0; ta = 1'b0; tb_t = 1'b0;
        end else begin
            if ((ro_enable | ro_enable1) & (16'd1 << ia)) begin
                ca++;
                if (ca == pa) begin ca = 0; ta = ~ta; end
            end
            if ((ro_enable | ro_enable1) & (16'd1 << ib)) begin
                cb++;
                if (cb == pb) begin cb = 0; tb_t = ~tb_t; end
            end
        end
        ro_in = '0;
        ro_in[ia] = ta;
        ro_in[ib] = tb_t;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge d_clk); #1; cyc++;
        end
    endtask

    task automatic accept(input int a, input int b, input int w);
        chal_a = 4'(a); chal_b = 4'(b); window = 16'(w); start = 1'b1;
        @(posedge d_clk); #1;
        start = 1'b0; cyc = 1;
    endtask

    task automatic wait_valid(input int lim);
        while (!resp_valid && cyc < lim) step(1);
    endtask

    task automatic handshake();
        resp_ready = 1'b1;
        step(1);
        resp_ready = 1'b0;
    endtask

    initial begin
        step(3);
        chk("rst_out", {ready, ready1, ro_enable, ro_reset, resp_valid, resp_bit, resp_tie, resp_err}, 0);
        reset = 1'b0;
        #1;
        chk("rst_ready", {ready, ready1}, 2'b11);

        ia = 2; ib = 7; pa = 3; pb = 5;
        accept(2, 7, 300);
        chk("clr_en", ro_enable, 16'h0084);
        chk("clr_rst", ro_reset, 1);
        step(5);
        chk("settle", {ro_enable, ro_reset}, {16'h0084, 1'b0});
        step(100);
        chk("meas_en", ro_enable, 16'h0084);
        wait_valid(400);
        chk("lat_310", cyc, 310);
        chk("resp_3v5", {resp_bit, resp_tie, resp_err}, 3'b100);
        chk("done_en", ro_enable, 0);
`ifdef RO_PUF_COUNTS_OUT_EN
        chk("cnt_a100", count_a, 100);
        chk("cnt_b60", count_b, 60);
`endif
        for (int i = 0; i < 20; i++) begin
            start = (i % 2 == 0);
            step(1);
            chk("hold", {resp_valid, resp_bit, resp_tie, resp_err, ready}, 5'b11000);
        end
        start = 1'b0;
        handshake();
        chk("after_hs", {resp_valid, ready}, 2'b01);

        ia = 0; ib = 1; pa = 4; pb = 4;
        accept(0, 1, 200);
        wait_valid(400);
        chk("lat_210", cyc, 210);
        chk("resp_tie", {resp_bit, resp_tie, resp_err}, 3'b010);
`ifdef RO_PUF_COUNTS_OUT_EN
        chk("cnt_tie", {count_a, count_b}, {16'd50, 16'd50});
`endif
        handshake();

        accept(5, 5, 100);
        chk("rej_en", ro_enable, 0);
        wait_valid(10);
        chk("rej_lat", cyc, 1);
        chk("rej_resp", {resp_valid, resp_bit, resp_tie, resp_err}, 4'b1001);
        handshake();
        accept(3, 4, 0);
        wait_valid(10);
        chk("win0_lat", cyc, 1);
        chk("win0_resp", {resp_valid, resp_bit, resp_tie, resp_err, ro_enable}, {4'b1001, 16'h0});
        handshake();

        ia = 0; ib = 1; pa = 2; pb = 0;
        chal_a = 4'd0; chal_b = 4'd1; window = 16'd64; start1 = 1'b1;
        @(posedge d_clk); #1;
        start1 = 1'b0; cyc = 1;
        while (!resp_valid1 && cyc < 200) step(1);
        chk("sat_lat", cyc, 74);
        chk("sat_resp", {resp_bit1, resp_tie1, resp_err1}, 3'b101);
`ifdef RO_PUF_COUNTS_OUT_EN
        chk("sat_cnt", {count_a1, count_b1}, {4'd15, 4'd0});
`endif
        handshake();
        chk("sat_idle", {resp_valid1, ready1}, 2'b01);

        ia = 2; ib = 7; pa = 3; pb = 5;
        accept(2, 7, 300);
        step(17);
        chk("pre_abort", ro_enable, 16'h0084);
        reset = 1'b1;
        step(1);
        chk("abort", {ready, ro_enable, ro_reset, resp_valid, resp_bit, resp_tie, resp_err}, 0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 350; i++) begin
            step(1);
            seen |= resp_valid;
        end
        chk("no_resp", seen, 0);
        chk("idle_ready", ready, 1);

        ia = 3; ib = 9; pa = 5; pb = 3;
        accept(3, 9, 30);
        chk("fresh_en", ro_enable, 16'h0208);
        wait_valid(100);
        chk("fresh_lat", cyc, 40);
        chk("fresh_resp", {resp_bit, resp_tie, resp_err}, 3'b000);
`ifdef RO_PUF_COUNTS_OUT_EN
        chk("fresh_cnt", {count_a, count_b}, {16'd6, 16'd10});
`endif
        handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ro_puf_controller.md
# ro_puf_controller

Measurement sequencer for the ring-oscillator PUF array. It takes a challenge naming two oscillators, enables only that pair, clears their toggle flops, and counts synchronized toggles of each for a programmable window. It then compares the two counts and returns one response bit through a valid/ready handshake. It sits between the host/challenge interface and the bank of `NUM_RO` ring-oscillator instances, driving their enable and reset pins and sampling their `dffout` outputs.

## Interface
Parameters:
- `NUM_RO`, 16: number of ring oscillators in the bank.
- `SEL_W`, 4: challenge index width; must satisfy 2^SEL_W ≥ NUM_RO.
- `WIN_W`, 16: measurement window length width, in d_clk cycles.
- `CNT_W`, 16: toggle counter width.
- `CLR_CYC`, 4: cycles `ro_reset` is held with the pair enabled.
- `SETTLE_CYC`, 4: cycles after the clear before counting starts.

Ports:
- `d_clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock d_clk.
- `start` in 1: challenge valid.
- `ready` out 1: controller idle and able to accept a challenge. Combinational: (state==IDLE) & ~reset.
- `chal_a` in SEL_W: index of oscillator A.
- `chal_b` in SEL_W: index of oscillator B.
- `window` in WIN_W: measurement length in cycles.
- `ro_enable` out NUM_RO: one-hot-pair enables to the oscillators.
- `ro_reset` out 1: shared reset to the oscillator toggle flops.
- `ro_in` in NUM_RO: asynchronous `dffout` toggles from the oscillators.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts the response.
- `resp_bit` out 1: 1 when count_A > count_B.
- `resp_tie` out 1: 1 when count_A == count_B.
- `resp_err` out 1: challenge rejected, or a counter saturated.

## Operation
- States: IDLE, CLEAR, SETTLE, MEASURE, COMPARE, DONE.
- **IDLE**
  - A challenge is accepted on a cycle with start & ready.
  - `chal_a`, `chal_b` and `window` are latched on acceptance.
  - If chal_a==chal_b, either index ≥ NUM_RO, or window==0: next state is DONE with resp_err=1, resp_bit=0 and resp_tie=0, and no oscillator is enabled.
  - Otherwise: next state is CLEAR.
- **CLEAR** (CLR_CYC cycles)
  - ro_enable has bits A and B set, all others 0.
  - ro_reset=1.
  - Both counters are zeroed.
- **SETTLE** (SETTLE_CYC cycles)
  - ro_reset=0; the pair stays enabled.
  - The synchronizers fill; no counting.
- **MEASURE** (exactly `window` cycles)
  - Each selected `ro_in` passes through a 2-flop synchronizer and then an edge register.
  - Every transition (either polarity) between the 2nd and 3rd flop increments that channel's counter.
  - Counters saturate at 2^CNT_W−1. Reaching saturation sets a sticky sat flag.
- **COMPARE** (1 cycle)
  - ro_enable=0.
  - Result registered: resp_bit = (cntA > cntB) and resp_tie = (cntA == cntB).
  - resp_err = sat flag. When resp_err=1, resp_bit and resp_tie are still reported.
- **DONE**
  - resp_valid=1, held with the result stable until resp_valid & resp_ready.
  - On that handshake: next state is IDLE, resp_valid=0.
- `start` while not ready is ignored and not queued.
- Reset values: state IDLE, ro_enable=0, ro_reset=0, resp_valid=0, resp_bit=0, resp_tie=0, resp_err=0, counters 0, sat flag 0. `ready`=0 while reset is high.
- Reset mid-measurement aborts immediately: enables drop on the next edge and no response is produced.
- The required `ro_in` toggle rate is below d_clk/2 for counts to be exact; faster inputs alias.

## Timing
- Acceptance edge = cycle 0.
- CLEAR occupies cycles 1..CLR_CYC.
- SETTLE occupies the next SETTLE_CYC cycles.
- MEASURE occupies the next `window` cycles.
- COMPARE occupies 1 cycle.
- resp_valid first rises at cycle 2 + CLR_CYC + SETTLE_CYC + window. With default parameters and window=100, that is cycle 110.
- Rejected challenge: resp_valid rises at cycle 1.
- The earliest next acceptance is the cycle after the resp_valid & resp_ready handshake.
- A transition in flight in the synchronizer when MEASURE ends is not counted.

## Configuration
- `RO_PUF_COUNTS_OUT_EN`
  - Defined: adds output ports `count_a` and `count_b` (CNT_W each). They carry the final counter values, valid with resp_valid and held until the handshake; their reset value is 0.
  - Undefined: the ports do not exist and the counters are internal only.
- Behaviour is otherwise identical with and without the macro.

## Test plan
- Model oscillator A toggling every 3 cycles and B every 5, with window=300, chal_a=2, chal_b=7 -> ro_enable=0x0084 during CLEAR/SETTLE/MEASURE; resp_bit=1, resp_tie=0, resp_err=0; resp_valid at cycle 310; counts 100 and 60 with RO_PUF_COUNTS_OUT_EN.
- Identical 4-cycle toggle models on both channels, window=200 -> resp_tie=1, resp_bit=0.
- chal_a=chal_b=5 -> resp_valid at cycle 1, resp_err=1, ro_enable remains 0.
- CNT_W=4, A toggling every 2 cycles, window=64 -> cntA stops at 15, resp_err=1.
- Hold resp_ready=0 for 20 cycles in DONE while pulsing start -> result stable, start ignored, ready=0; accept after the handshake.
- Assert reset at MEASURE cycle 10 -> ro_enable=0 and all outputs at reset values the next cycle; no resp_valid; a fresh challenge completes normally.
